// File: rtl/data_demux_rx_1.sv
// Receive-side data demux: assembles big-endian register bytes of a function-03 response into
// a shadow bank and commits the whole bank atomically only on a complete frame with a good CRC.
module data_demux_rx_1 #(
  parameter int adr_first_reg_read = 340,
  parameter int num_reg_read       = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_start,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic        rx_frame_end,
  input  logic        rx_crc_ok,
  output logic [15:0] data_340_1,
  output logic [15:0] data_341_1,
  output logic [15:0] data_342_1,
  output logic [15:0] data_343_1,
  output logic [15:0] data_344_1,
  output logic [15:0] data_345_1,
  output logic [15:0] data_346_1,
  output logic [15:0] data_347_1,
  output logic [15:0] data_348_1,
  output logic [15:0] data_349_1,
  output logic [15:0] data_350_1,
  output logic [15:0] data_351_1,
  output logic [15:0] data_352_1,
  output logic [15:0] data_353_1,
  output logic [15:0] data_354_1,
  output logic [15:0] data_355_1,
  output logic [15:0] data_356_1,
  output logic [15:0] data_357_1,
  output logic [15:0] data_358_1,
  output logic [15:0] data_359_1,
  output logic [15:0] data_360_1,
  output logic [15:0] data_361_1,
  output logic [15:0] data_362_1,
  output logic [15:0] data_363_1,
  output logic [15:0] data_364_1,
  output logic [15:0] data_365_1,
  output logic [15:0] data_366_1,
  output logic [15:0] data_367_1,
  output logic [15:0] data_368_1,
  output logic [15:0] data_369_1,
  output logic        update_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic [4:0]  word_idx,
  output logic        busy
);

  localparam int unsigned MAX_WORDS = 30;
  localparam int unsigned NUM_U     = num_reg_read;
  localparam logic [4:0]  NUM_W     = 5'(num_reg_read);

  if (num_reg_read < 1 || num_reg_read > 30 ||
      adr_first_reg_read < 0 || adr_first_reg_read > 65506) begin : g_param_check
    $error("data_demux_rx_1: illegal parameter values");
  end

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [4:0]  word_idx_q, word_idx_d;
  logic        overrun_q, overrun_d;
  logic        update_ok_q, update_ok_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] shadow_q [MAX_WORDS];
  logic [15:0] shadow_d [MAX_WORDS];
  logic [15:0] data_q   [MAX_WORDS];
  logic [15:0] data_d   [MAX_WORDS];

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    word_idx_d  = word_idx_q;
    overrun_d   = overrun_q;
    err_cnt_d   = err_cnt_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    update_ok_d = 1'b0;
    frame_err_d = 1'b0;

    // Priority: rx_start aborts silently, frame end beats a same-cycle byte.
    if (rx_start) begin
      state_d    = HI;
      word_idx_d = '0;
      overrun_d  = 1'b0;
    end else if (rx_frame_end && state_q != IDLE) begin
      state_d = IDLE;
      if (state_q == DONE && rx_crc_ok && !overrun_q) begin
        for (int unsigned k = 0; k < NUM_U; k++) data_d[k] = shadow_q[k];
        update_ok_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
      end
    end else if (rx_byte_valid) begin
      case (state_q)
        HI: begin
          hi_d    = rx_byte;
          state_d = LO;
        end
        LO: begin
          shadow_d[word_idx_q] = {hi_q, rx_byte};
          word_idx_d           = word_idx_q + 5'd1;
          state_d              = (word_idx_d == NUM_W) ? DONE : HI;
        end
        DONE:    overrun_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      word_idx_q  <= '0;
      overrun_q   <= 1'b0;
      update_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      for (int unsigned k = 0; k < MAX_WORDS; k++) begin
        shadow_q[k] <= '0;
        data_q[k]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      word_idx_q  <= word_idx_d;
      overrun_q   <= overrun_d;
      update_ok_q <= update_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
    end
  end

  assign update_ok = update_ok_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign word_idx  = word_idx_q;
  assign busy      = (state_q != IDLE);

  assign data_340_1 = data_q[0];
  assign data_341_1 = data_q[1];
  assign data_342_1 = data_q[2];
  assign data_343_1 = data_q[3];
  assign data_344_1 = data_q[4];
  assign data_345_1 = data_q[5];
  assign data_346_1 = data_q[6];
  assign data_347_1 = data_q[7];
  assign data_348_1 = data_q[8];
  assign data_349_1 = data_q[9];
  assign data_350_1 = data_q[10];
  assign data_351_1 = data_q[11];
  assign data_352_1 = data_q[12];
  assign data_353_1 = data_q[13];
  assign data_354_1 = data_q[14];
  assign data_355_1 = data_q[15];
  assign data_356_1 = data_q[16];
  assign data_357_1 = data_q[17];
  assign data_358_1 = data_q[18];
  assign data_359_1 = data_q[19];
  assign data_360_1 = data_q[20];
  assign data_361_1 = data_q[21];
  assign data_362_1 = data_q[22];
  assign data_363_1 = data_q[23];
  assign data_364_1 = data_q[24];
  assign data_365_1 = data_q[25];
  assign data_366_1 = data_q[26];
  assign data_367_1 = data_q[27];
  assign data_368_1 = data_q[28];
  assign data_369_1 = data_q[29];

endmodule
